// File: rtl/interconnect_rr_arbiter_if.sv
// Request/grant bundle between the interconnect masters and the round-robin arbiter.
interface interconnect_rr_arbiter_if #(
  parameter int NUM_MASTERS = 4
) ();
  localparam int SEL_W = $clog2(NUM_MASTERS + 1);

  logic [NUM_MASTERS-1:0] i_Req;
  logic [NUM_MASTERS-1:0] i_Last;
  logic                   i_Ready;
  logic [NUM_MASTERS-1:0] o_Grant;
  logic [SEL_W-1:0]       o_MuxSel;
  logic                   o_Busy;
  logic                   o_Timeout;

  // Requester side: drives requests and slave handshake, observes the grant.
  modport master (
    output i_Req, i_Last, i_Ready,
    input  o_Grant, o_MuxSel, o_Busy, o_Timeout
  );

  // Arbiter side.
  modport slave (
    input  i_Req, i_Last, i_Ready,
    output o_Grant, o_MuxSel, o_Busy, o_Timeout
  );
endinterface

// File: rtl/interconnect_rr_arbiter.sv
// Round-robin arbiter sharing one slave port among NUM_MASTERS requesters.
// Define ARB_TIMEOUT_EN to add a watchdog that force-releases a grant whose slave stops answering.
module interconnect_rr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                      i_Clk,
  input logic                      i_Reset,
  interconnect_rr_arbiter_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_MASTERS + 1);
  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [SEL_W-1:0]       SEL_NONE = SEL_W'(NUM_MASTERS);
  localparam logic [NUM_MASTERS-1:0] LSB_ONLY = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state_r;
  logic [NUM_MASTERS-1:0] grant_r;
  logic [SEL_W-1:0]       sel_r;
  logic                   busy_r;
  logic                   timeout_r;
  logic [PTR_W-1:0]       ptr_r;

  logic             req_cur_s;
  logic             done_s;
  logic             abort_s;
  logic             expire_s;
  logic             release_s;
  logic [PTR_W-1:0] next_ptr_s;
  logic [PTR_W-1:0] search_start_s;
  logic [SEL_W-1:0] win_s;

  // First requester at or after start, wrapping; SEL_NONE when nobody asks.
  function automatic logic [SEL_W-1:0] pick_f(input logic [NUM_MASTERS-1:0] req,
                                              input logic [PTR_W-1:0] start);
    logic [SEL_W-1:0] win;
    int idx;
    win = SEL_NONE;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      idx = (int'(start) + i) % NUM_MASTERS;
      if ((req & (LSB_ONLY << idx)) != '0) win = SEL_W'(idx);
      else win = win;
    end
    return win;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr_f(input logic [SEL_W-1:0] g);
    if (int'(g) >= NUM_MASTERS - 1) return '0;
    else return PTR_W'(int'(g) + 1);
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;

  // Watchdog: counts BUSY cycles with no slave response, cleared whenever the grant changes.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) cnt_r <= '0;
    else if (state_r != BUSY || release_s || bus.i_Ready) cnt_r <= '0;
    else if (cnt_r != CNT_MAX) cnt_r <= cnt_r + CNT_ONE;
    else cnt_r <= cnt_r;
  end

  // A still-requesting master whose slave stayed silent too long; exclusive with done and abort.
  assign expire_s = (state_r == BUSY) && req_cur_s && !bus.i_Ready && (cnt_r == CNT_MAX);
`else
  assign expire_s = 1'b0;
`endif

  // Release conditions for the current grant and the round-robin winner for the next edge.
  always_comb begin
    req_cur_s  = |(bus.i_Req & grant_r);
    done_s     = (state_r == BUSY) && bus.i_Ready && (|(bus.i_Last & grant_r));
    abort_s    = (state_r == BUSY) && !req_cur_s && !done_s;
    release_s  = done_s || abort_s || expire_s;
    next_ptr_s = next_ptr_f(sel_r);
    if (state_r == BUSY) search_start_s = next_ptr_s;
    else search_start_s = ptr_r;
    win_s = pick_f(bus.i_Req, search_start_s);
  end

  // Grant FSM with registered grant, mux select, busy and timeout pulse.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_r   <= IDLE;
      grant_r   <= '0;
      sel_r     <= SEL_NONE;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
      ptr_r     <= '0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (win_s != SEL_NONE) begin
            grant_r <= LSB_ONLY << win_s;
            sel_r   <= win_s;
            busy_r  <= 1'b1;
            state_r <= BUSY;
          end else begin
            grant_r <= '0;
            sel_r   <= SEL_NONE;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (release_s) begin
            ptr_r     <= next_ptr_s;
            timeout_r <= expire_s;
            if (win_s != SEL_NONE) begin
              grant_r <= LSB_ONLY << win_s;
              sel_r   <= win_s;
              busy_r  <= 1'b1;
              state_r <= BUSY;
            end else begin
              grant_r <= '0;
              sel_r   <= SEL_NONE;
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end
          end else begin
            grant_r <= grant_r;
            sel_r   <= sel_r;
            busy_r  <= busy_r;
            state_r <= BUSY;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= '0;
          sel_r   <= SEL_NONE;
          busy_r  <= 1'b0;
          ptr_r   <= '0;
        end
      endcase
    end
  end

  assign bus.o_Grant   = grant_r;
  assign bus.o_MuxSel  = sel_r;
  assign bus.o_Busy    = busy_r;
  assign bus.o_Timeout = timeout_r;
endmodule
